// File: rtl/t5_lsu_rsp.sv
// Data-bus response stage: waits for dwb_ack, stalls the pipeline while a cycle is
// outstanding, aligns and extends load data, and aborts on timeout or illegal lanes.
module t5_lsu_rsp #(
    parameter int TMO  = 255,
    parameter int CNTW = 8
) (
    input  logic        sclk,
    input  logic        srst,
    input  logic        sena,
    input  logic        xstb,
    input  logic        xwre,
    input  logic [3:0]  xsel,
    input  logic [2:0]  xfn3,
    input  logic [4:0]  xrd,
    input  logic [31:0] dwb_dti,
    input  logic        dwb_ack,
    output logic        mstall,
    output logic [31:0] mdat,
    output logic [4:0]  mrd,
    output logic        mvld,
    output logic        merr
);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

    localparam logic [CNTW-1:0] TMO_C = CNTW'(TMO);
    localparam logic [CNTW-1:0] ONE_C = CNTW'(1);

    state_t          state_r;
    logic [CNTW-1:0] cnt_r;
    logic            legal_s;
    logic            complete_s;
    logic            tmo_s;
    logic            bad_s;

    function automatic logic lanes_ok(input logic wre, input logic [2:0] fn3, input logic [3:0] sel);
        logic byte_ok;
        logic half_ok;
        logic ok;
        byte_ok = (sel == 4'h1) || (sel == 4'h2) || (sel == 4'h4) || (sel == 4'h8);
        half_ok = (sel == 4'h3) || (sel == 4'hC);
        case (fn3)
            3'b000:  ok = byte_ok;
            3'b100:  ok = byte_ok && !wre;
            3'b001:  ok = half_ok;
            3'b101:  ok = half_ok && !wre;
            3'b010:  ok = (sel == 4'hF);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] align_load(input logic [2:0] fn3, input logic [3:0] sel,
                                               input logic [31:0] dti);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (sel)
            4'h2:    b = dti[15:8];
            4'h4:    b = dti[23:16];
            4'h8:    b = dti[31:24];
            default: b = dti[7:0];
        endcase
        if (sel[3]) begin
            h = dti[31:16];
        end else begin
            h = dti[15:0];
        end
        case (fn3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = dti;
        endcase
        return r;
    endfunction

    // Per-cycle decision: stall, completion, timeout or lane error.
    always_comb begin
        legal_s    = lanes_ok(xwre, xfn3, xsel);
        mstall     = 1'b0;
        complete_s = 1'b0;
        tmo_s      = 1'b0;
        bad_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (!xstb) begin
                    mstall = 1'b0;
                end else if (!legal_s) begin
                    bad_s = 1'b1;
                end else if (dwb_ack) begin
                    complete_s = 1'b1;
                end else begin
                    mstall = 1'b1;
                end
            end
            WAIT: begin
                if (!xstb) begin
                    mstall = 1'b0;
                end else if (dwb_ack) begin
                    complete_s = 1'b1;
                end else if (cnt_r == TMO_C) begin
                    tmo_s = 1'b1;
                end else begin
                    mstall = 1'b1;
                end
            end
            default: mstall = 1'b0;
        endcase
    end

    // State, timeout counter and registered writeback outputs.
    always_ff @(posedge sclk) begin
        if (srst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            mdat    <= 32'd0;
            mrd     <= 5'd0;
            mvld    <= 1'b0;
            merr    <= 1'b0;
        end else begin
            mvld <= complete_s && !xwre;
            merr <= bad_s || tmo_s;
            if (complete_s && !xwre) begin
                mdat <= align_load(xfn3, xsel, dwb_dti);
                mrd  <= xrd;
            end
            case (state_r)
                IDLE: begin
                    if (mstall) begin
                        state_r <= WAIT;
                        cnt_r   <= ONE_C;
                    end else if (complete_s && !sena) begin
                        state_r <= DONE;
                    end
                end
                WAIT: begin
                    if (mstall) begin
                        cnt_r <= cnt_r + ONE_C;
                    end else begin
                        cnt_r   <= '0;
                        // A completion under a frozen pipeline parks until sena releases it.
                        state_r <= (complete_s && !sena) ? DONE : IDLE;
                    end
                end
                DONE: begin
                    if (sena) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t5_lsu_rsp.sv
// Directed bench for t5_lsu_rsp: a transaction-level model predicts the per-cycle
// outputs; one negedge process compares them, plus literal spot checks.
module tb_t5_lsu_rsp;

    localparam int TMO  = 4;
    localparam int NEVER = 99;

    logic        sclk = 1'b0;
    logic        srst, sena, xstb, xwre, dwb_ack;
    logic [3:0]  xsel;
    logic [2:0]  xfn3;
    logic [4:0]  xrd;
    logic [31:0] dwb_dti;
    logic        mstall, mvld, merr;
    logic [31:0] mdat;
    logic [4:0]  mrd;

    int          total = 0;
    int          passes = 0;
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_vld, exp_err;
    logic [31:0] exp_dat;
    logic [4:0]  exp_rd;

    t5_lsu_rsp #(.TMO(TMO), .CNTW(3)) dut (
        .sclk(sclk), .srst(srst), .sena(sena), .xstb(xstb), .xwre(xwre),
        .xsel(xsel), .xfn3(xfn3), .xrd(xrd), .dwb_dti(dwb_dti), .dwb_ack(dwb_ack),
        .mstall(mstall), .mdat(mdat), .mrd(mrd), .mvld(mvld), .merr(merr)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    function automatic int low_lane(input logic [3:0] sel);
        for (int i = 3; i >= 0; i--) begin
            if (sel[i]) low_lane = i;
        end
        if (sel == 4'h0) low_lane = 0;
    endfunction

    // Legality from access size and lane count/position.
    function automatic logic m_legal(input logic wre, input logic [2:0] fn3, input logic [3:0] sel);
        int lo;
        int n;
        lo = low_lane(sel);
        n  = $countones(sel);
        if (fn3[1:0] == 2'b11) return 1'b0;
        if (fn3[2] && (wre || fn3[1])) return 1'b0;
        if (fn3[1:0] == 2'b00) return n == 1;
        if (fn3[1:0] == 2'b01) return (n == 2) && (lo % 2 == 0) && sel[lo+1];
        return sel == 4'hF;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] fn3, input logic [3:0] sel,
                                           input logic [31:0] dti);
        logic [31:0]        sh;
        logic signed [7:0]  sb;
        logic signed [15:0] sw;
        logic signed [31:0] r;
        sh = dti >> (8 * low_lane(sel));
        sb = sh[7:0];
        sw = sh[15:0];
        if (fn3 == 3'b000) r = sb;
        else if (fn3 == 3'b001) r = sw;
        else if (fn3 == 3'b100) r = {24'd0, sh[7:0]};
        else if (fn3 == 3'b101) r = {16'd0, sh[15:0]};
        else r = dti;
        return r;
    endfunction

    always @(negedge sclk) begin
        if (chk_en) begin
            chk("mstall", 32'(mstall), 32'(exp_stall));
            chk("mvld", 32'(mvld), 32'(exp_vld));
            chk("merr", 32'(merr), 32'(exp_err));
            chk("mdat", mdat, exp_dat);
            chk("mrd", 32'(mrd), 32'(exp_rd));
        end
    end

    // One cycle: current-cycle stall expectation, then what the registers hold afterwards.
    task automatic tick(input logic st, input logic v, input logic e,
                        input logic [31:0] d, input logic [4:0] r);
        exp_stall = st;
        @(posedge sclk);
        exp_vld = v;
        exp_err = e;
        if (v) begin
            exp_dat = d;
            exp_rd  = r;
        end
        #1;
    endtask

    // One access with ack after d cycles (d > TMO means no ack), followed by an idle cycle.
    task automatic access(input logic wre, input logic [2:0] fn3, input logic [3:0] sel,
                          input logic [4:0] rd, input logic [31:0] dti, input int d);
        logic        ok;
        logic [31:0] res;
        int          n;
        ok  = m_legal(wre, fn3, sel);
        res = m_load(fn3, sel, dti);
        xstb = 1'b1; xwre = wre; xfn3 = fn3; xsel = sel; xrd = rd; dwb_dti = dti;
        if (!ok) begin
            dwb_ack = 1'b0;
            tick(1'b0, 1'b0, 1'b1, 32'd0, 5'd0);
        end else begin
            n = (d <= TMO) ? d : TMO;
            for (int k = 0; k < n; k++) begin
                dwb_ack = 1'b0;
                tick(1'b1, 1'b0, 1'b0, 32'd0, 5'd0);
            end
            dwb_ack = (d <= TMO);
            tick(1'b0, (d <= TMO) && !wre, d > TMO, res, rd);
        end
        xstb = 1'b0; dwb_ack = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 32'd0, 5'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        srst = 1'b1; sena = 1'b1; xstb = 1'b0; xwre = 1'b0; xsel = 4'h0; xfn3 = 3'b000;
        xrd = 5'd0; dwb_dti = 32'd0; dwb_ack = 1'b0;
        exp_stall = 1'b0; exp_vld = 1'b0; exp_err = 1'b0; exp_dat = 32'd0; exp_rd = 5'd0;
        repeat (2) @(posedge sclk);
        #1;
        chk_en = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 32'd0, 5'd0);
        srst = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 32'd0, 5'd0);

        chk("pin_lb", m_load(3'b000, 4'h4, 32'h0080_0000), 32'hFFFF_FF80);
        chk("pin_lhu", m_load(3'b101, 4'hC, 32'h8001_1234), 32'h0000_8001);
        chk("pin_lh6", 32'(m_legal(1'b0, 3'b001, 4'h6)), 32'd0);

        access(1'b0, 3'b000, 4'h4, 5'd3, 32'h0080_0000, 0);
        chk("t1_mdat", mdat, 32'hFFFF_FF80);
        access(1'b0, 3'b101, 4'hC, 5'd7, 32'h8001_1234, 3);
        chk("t2_mdat", mdat, 32'h0000_8001);
        access(1'b0, 3'b010, 4'hF, 5'd9, 32'hDEAD_BEEF, NEVER);
        chk("t3_mdat_kept", mdat, 32'h0000_8001);
        access(1'b1, 3'b010, 4'hF, 5'd0, 32'h0, 1);
        access(1'b0, 3'b001, 4'h6, 5'd4, 32'h1234_5678, 0);
        access(1'b0, 3'b100, 4'h8, 5'd11, 32'hA5B6_C7D8, 2);
        access(1'b0, 3'b001, 4'h3, 5'd12, 32'h0000_9ABC, 0);
        access(1'b0, 3'b010, 4'hF, 5'd13, 32'h7654_3210, TMO);
        chk("ack_at_tmo", mdat, 32'h7654_3210);
        access(1'b0, 3'b000, 4'h1, 5'd14, 32'h0000_007F, 1);
        access(1'b1, 3'b000, 4'h2, 5'd0, 32'h0, 0);
        access(1'b1, 3'b101, 4'h3, 5'd0, 32'h0, 0);
        access(1'b0, 3'b011, 4'hF, 5'd1, 32'h0, 0);
        access(1'b0, 3'b010, 4'h7, 5'd1, 32'h0, 0);
        access(1'b0, 3'b000, 4'h0, 5'd1, 32'h0, 0);
        access(1'b0, 3'b100, 4'h6, 5'd1, 32'h0, 0);

        // Completion while the pipeline is frozen: one writeback only.
        xstb = 1'b1; xwre = 1'b0; xfn3 = 3'b010; xsel = 4'hF; xrd = 5'd21;
        dwb_dti = 32'hCAFE_F00D; dwb_ack = 1'b1; sena = 1'b0;
        tick(1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, 5'd21);
        tick(1'b0, 1'b0, 1'b0, 32'd0, 5'd0);
        sena = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 32'd0, 5'd0);
        xstb = 1'b0; dwb_ack = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 32'd0, 5'd0);
        access(1'b0, 3'b100, 4'h2, 5'd22, 32'h0000_F100, 0);

        // Reset in the middle of a wait drops the access and clears outputs.
        xstb = 1'b1; xwre = 1'b0; xfn3 = 3'b010; xsel = 4'hF; xrd = 5'd5;
        dwb_dti = 32'h1111_2222; dwb_ack = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 32'd0, 5'd0);
        tick(1'b1, 1'b0, 1'b0, 32'd0, 5'd0);
        srst = 1'b1; xstb = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 32'd0, 5'd0);
        exp_dat = 32'd0; exp_rd = 5'd0;
        srst = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 32'd0, 5'd0);
        chk("rst_mdat", mdat, 32'd0);
        access(1'b0, 3'b000, 4'h8, 5'd30, 32'h8000_0000, 0);
        chk("post_rst_mdat", mdat, 32'hFFFF_FF80);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
